// File: rtl/sipo_deser_pkg.sv
// Shared constants and helpers for the serializer/deserializer pair.
//   DEFAULT_WIDTH : default word length in bits
//   ctr_width()   : bit-counter width for a given word length
package sipo_deser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter width for a modulo-w bit counter; never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_deser_bit_ctr.sv
// Modulo-MODULUS bit counter with enable and synchronous reset.
//   clk, rst : clock, synchronous active-high reset
//   en       : count one bit this cycle
//   done_c   : terminal count reached on an enabled cycle (combinational)
//   busy     : registered, counter is mid-word (count != 0)
module bit_ctr #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned CW      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done_c,
  output logic busy
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] cnt;

  assign done_c = en && (cnt == LAST);

  // Count enabled bits, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (en) begin
      cnt  <= done_c ? '0 : cnt + CW'(1);
      busy <= !done_c;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a one-word output holding register.
//   clk, rst   : clock, synchronous active-high reset
//   sin, sin_en: serial bit and its qualifier
//   pout       : assembled word, pout_valid/pout_ready handshake
//   busy       : partial word in progress
//   overrun    : sticky, a completed word was dropped while stalled
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = ctr_width(WIDTH);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             done_c;
  logic             load;
  logic             set_ovr;

  bit_ctr #(
    .MODULUS (WIDTH),
    .CW      (CW)
  ) u_bit_ctr (
    .clk    (clk),
    .rst    (rst),
    .en     (sin_en),
    .done_c (done_c),
    .busy   (busy)
  );

  // Next shift-register value; on completion this is the finished word.
  always_comb begin
    sh_nxt = sh;
    if (sin_en) begin
      if (MSB_FIRST != 0) sh_nxt = {sh[WIDTH-2:0], sin};
      else                sh_nxt = {sin, sh[WIDTH-1:1]};
    end
  end

  // Holding-register next state: accept and reload in one cycle when possible.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      EMPTY: begin
        if (done_c) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      default: begin
        if (done_c) begin
          if (pout_ready) load    = 1'b1;
          else            set_ovr = 1'b1;
        end else if (pout_ready) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  // State, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      sh      <= '0;
      pout    <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      if (load)    pout    <= sh_nxt;
      if (set_ovr) overrun <= 1'b1;
    end
  end

  assign pout_valid = (state == FULL);

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that sits directly downstream of the 4-bit parallel-to-serial stage. It samples the serial bit stream, assembles `WIDTH`-bit words and presents each one on a valid/ready parallel output. A one-word output holding register absorbs consumer stalls. A sticky flag reports words lost to overrun.

## Interface
- `WIDTH`, default 4: word length in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = first received bit lands in `pout[WIDTH-1]`, which matches the upstream serializer; 0 = first received bit lands in `pout[0]`.
- `clk` input, 1 bit: single clock; all flops update on its rising edge. Upstream drives `sin` on the falling edge, so sampling lands mid-bit.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sin` input, 1 bit: serial data bit.
- `sin_en` input, 1 bit: `sin` is a valid bit this cycle.
- `pout` output, `WIDTH` bits: assembled word.
- `pout_valid` output, 1 bit: `pout` holds an unconsumed word.
- `pout_ready` input, 1 bit: consumer accepts `pout` this cycle.
- `busy` output, 1 bit: a partial word is in progress (bit count ≠ 0).
- `overrun` output, 1 bit: sticky; a completed word was dropped.

## Operation
**Receive state**
- State: shift register `sh[WIDTH-1:0]` and bit counter `cnt` in 0..`WIDTH-1`, width `$clog2(WIDTH)`.
- Cycle with `sin_en`=0: no change to `sh` or `cnt`.

**Shift rule (when `sin_en`=1)**
- `MSB_FIRST`=1: `sh` ← {`sh[WIDTH-2:0]`, `sin`}.
- `MSB_FIRST`=0: `sh` ← {`sin`, `sh[WIDTH-1:1]`}.

**Word completion**
- Occurs when `sin_en`=1 and `cnt`=`WIDTH-1`.
- `cnt` wraps to 0.
- The next-state value of `sh` (including the current bit) is the completed word.
- Otherwise, when `sin_en`=1, `cnt` increments.

**Output holding register: two states, EMPTY and FULL**
- EMPTY, no completion: stays EMPTY.
- EMPTY, completion: load `pout` with the word; go FULL.
- FULL, `pout_ready`=1, no completion: go EMPTY. `pout` keeps its last value.
- FULL, `pout_ready`=1, completion in the same cycle: load the new word; stay FULL. This gives back-to-back transfers with no bubble.
- FULL, `pout_ready`=0, completion: discard the new word; `pout` unchanged; set `overrun`=1.
- `pout_valid` equals (state == FULL).
- `pout_ready` while EMPTY is ignored.

**Overrun flag**
- `overrun` clears only on `rst`.
- Receive continues normally after an overrun: the counter is not disturbed.

## Timing
- Reset values: `pout`=0, `pout_valid`=0, `busy`=0, `overrun`=0, `sh`=0, `cnt`=0, holding state EMPTY.
- Reset mid-word: the partial word is discarded. The next `sin_en` bit is bit 0 of a new word.
- Reset while FULL: the held word is lost and `pout_valid` drops on the next edge.
- Latency: the last bit is sampled at edge *k*; `pout`/`pout_valid` are updated at edge *k*, i.e. visible during cycle *k*+1.
- Handshake: transfer happens when `pout_valid`=1 and `pout_ready`=1 at a rising edge. `pout` is stable while `pout_valid`=1 and not yet accepted.
- Throughput: one word per `WIDTH` enabled cycles. Continuous `sin_en`=1 with `pout_ready` tied high never overruns.
- `busy` is registered (`cnt` ≠ 0). It rises after the first bit of a word and falls at the completion edge.
- No combinational path from `pout_ready` to any output.

## Structure
- Shared package: default word width constant (4) and the counter-width helper (`$clog2`-based), shared with the serializer side.
- One sub-module: `bit_ctr`, a modulo-`WIDTH` counter with enable, synchronous reset and a terminal-count output. It drives word completion.
- Shift register and holding-register FSM stay in the top module.

## Test plan
- MSB-first, `WIDTH`=4: reset, then bits 1,0,1,1 with `sin_en`=1 and `pout_ready`=1 → `pout`=4'hB and `pout_valid`=1 for exactly one cycle after the 4th edge; `busy` is 1 for cycles 2–4.
- `MSB_FIRST`=0: the same bits 1,0,1,1 → `pout`=4'hD.
- Gapped `sin_en`: bits 0,1,1,0 with idle cycles between them → `pout`=4'h6; `cnt` holds during the idle cycles.
- Stall/overrun: `pout_ready`=0, send 4'hA then 4'h5 → `pout` stays 4'hA, `overrun`=1. Raise `pout_ready` → 4'hA accepted. Then send 4'h3 → `pout`=4'h3; `overrun` stays 1.
- Simultaneous accept and completion: hold 4'hC, assert `pout_ready` on the cycle 4'h9 completes → `pout`=4'h9, `pout_valid` stays 1, `overrun`=0.
- Reset mid-word after 2 bits, then bits 1,1,1,0 → `pout`=4'hE; all outputs were 0 in the cycle after `rst`.
